dec_imm_stage: RTL

- Registered decode-stage slice of the RV32I core, between fetch and execute.
- Accepts instruction/PC beats over valid/ready and classifies the opcode into an immediate format.
- Emits the sign-extended immediate, format tag, illegal-opcode flag and PC-relative target (pc + imm).
- A 2-entry skid buffer fully decouples the fetch-side ready from the execute-side ready.

---
 rtl/dec_pkg.sv | 43 ++++
 rtl/imm_classify.sv | 42 ++++
 rtl/dec_imm_stage.sv | 133 +++++++++++++
 3 files changed

// File: rtl/dec_pkg.sv
// Shared types for the RV32I decode-stage immediate slice: format tags,
// base opcodes, the buffered beat record and the skid occupancy encoding.
package dec_pkg;

    localparam int XLEN = 32;

    typedef enum logic [2:0] {
        IMM_NONE = 3'd0,
        IMM_I    = 3'd1,
        IMM_S    = 3'd2,
        IMM_B    = 3'd3,
        IMM_U    = 3'd4,
        IMM_J    = 3'd5
    } imm_type_e;

    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_OP       = 7'b0110011;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
        logic [31:0] imm;
        imm_type_e   imm_type;
        logic        illegal;
        logic [31:0] target;
    } dec_beat_t;

    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_TWO   = 2'd2
    } occ_e;

endpackage

// File: rtl/imm_classify.sv
// Combinational opcode classifier: maps an instruction word to its immediate
// format, the sign-extended immediate and an illegal-opcode flag.
module imm_classify
    import dec_pkg::*;
(
    input  logic [31:0] inst_i,
    output logic [31:0] imm_o,
    output imm_type_e   imm_type_o,
    output logic        illegal_o
);

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        imm_type_o = IMM_NONE;
        illegal_o  = 1'b0;
        case (inst_i[6:0])
            OPC_LUI, OPC_AUIPC:                 imm_type_o = IMM_U;
            OPC_JAL:                            imm_type_o = IMM_J;
            OPC_JALR, OPC_LOAD, OPC_OP_IMM,
            OPC_MISC_MEM, OPC_SYSTEM:           imm_type_o = IMM_I;
            OPC_STORE:                          imm_type_o = IMM_S;
            OPC_BRANCH:                         imm_type_o = IMM_B;
            OPC_OP:                             imm_type_o = IMM_NONE;
            default:                            illegal_o  = 1'b1;
        endcase
    end

    always_comb begin
        imm_o = '0;
        case (imm_type_o)
            IMM_I: imm_o = {{20{inst_i[31]}}, inst_i[31:20]};
            IMM_S: imm_o = {{20{inst_i[31]}}, inst_i[31:25], inst_i[11:7]};
            IMM_B: imm_o = {{19{inst_i[31]}}, inst_i[31], inst_i[7],
                            inst_i[30:25], inst_i[11:8], 1'b0};
            IMM_U: imm_o = {inst_i[31:12], 12'b0};
            IMM_J: imm_o = {{11{inst_i[31]}}, inst_i[31], inst_i[19:12],
                            inst_i[20], inst_i[30:21], 1'b0};
            default: imm_o = '0;
        endcase
    end

endmodule

// File: rtl/dec_imm_stage.sv
// Registered decode slice between fetch and execute: classifies the beat,
// computes pc + imm on the input side and buffers results in a 2-entry skid.
module dec_imm_stage
    import dec_pkg::*;
#(
    parameter int XLEN          = 32,
    parameter int ILLEGAL_CNT_W = 16
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     flush_i,
    input  logic                     in_valid_i,
    output logic                     in_ready_o,
    input  logic [31:0]              inst_i,
    input  logic [XLEN-1:0]          pc_i,
    output logic                     out_valid_o,
    input  logic                     out_ready_i,
    output logic [31:0]              out_inst_o,
    output logic [XLEN-1:0]          out_pc_o,
    output logic [XLEN-1:0]          out_imm_o,
    output logic [2:0]               out_imm_type_o,
    output logic                     out_illegal_o,
    output logic [XLEN-1:0]          out_target_o,
    output logic [ILLEGAL_CNT_W-1:0] illegal_cnt_o
);

    logic [31:0] in_imm;
    imm_type_e   in_imm_type;
    logic        in_illegal;
    dec_beat_t   in_beat;

    occ_e                     occ_q, occ_d;
    dec_beat_t                main_q, main_d;
    dec_beat_t                skid_q, skid_d;
    logic                     ready_q, ready_d;
    logic [ILLEGAL_CNT_W-1:0] cnt_q, cnt_d;

    logic accept;
    logic emit;

    imm_classify u_imm_classify (
        .inst_i     (inst_i),
        .imm_o      (in_imm),
        .imm_type_o (in_imm_type),
        .illegal_o  (in_illegal)
    );

    always_comb begin
        in_beat          = '0;
        in_beat.inst     = inst_i;
        in_beat.pc       = pc_i;
        in_beat.imm      = in_imm;
        in_beat.imm_type = in_imm_type;
        in_beat.illegal  = in_illegal;
        in_beat.target   = pc_i + in_imm;
    end

    assign accept = in_valid_i && ready_q;
    assign emit   = (occ_q != OCC_EMPTY) && out_ready_i;

    always_comb begin
        occ_d  = occ_q;
        main_d = main_q;
        skid_d = skid_q;
        if (flush_i) begin
            occ_d = OCC_EMPTY;
        end else begin
            case (occ_q)
                OCC_EMPTY: begin
                    if (accept) begin
                        occ_d  = OCC_ONE;
                        main_d = in_beat;
                    end
                end
                OCC_ONE: begin
                    if (accept && emit) begin
                        main_d = in_beat;
                    end else if (accept) begin
                        occ_d  = OCC_TWO;
                        skid_d = in_beat;
                    end else if (emit) begin
                        occ_d = OCC_EMPTY;
                    end
                end
                OCC_TWO: begin
                    // ready is low here, so only a drain can happen
                    if (emit) begin
                        occ_d  = OCC_ONE;
                        main_d = skid_q;
                    end
                end
                default: occ_d = OCC_EMPTY;
            endcase
        end
    end

    always_comb begin
        ready_d = (occ_d != OCC_TWO);
        cnt_d   = cnt_q;
        if (emit && main_q.illegal && (cnt_q != '1)) begin
            cnt_d = cnt_q + ILLEGAL_CNT_W'(1);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    // NOTE: both entries are reset: main drives the outputs, which must read zero in reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            occ_q   <= OCC_EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
            ready_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            occ_q   <= occ_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
            ready_q <= ready_d;
            cnt_q   <= cnt_d;
        end
    end

    assign in_ready_o     = ready_q;
    assign out_valid_o    = (occ_q != OCC_EMPTY);
    assign out_inst_o     = main_q.inst;
    assign out_pc_o       = main_q.pc;
    assign out_imm_o      = main_q.imm;
    assign out_imm_type_o = main_q.imm_type;
    assign out_illegal_o  = main_q.illegal;
    assign out_target_o   = main_q.target;
    assign illegal_cnt_o  = cnt_q;

endmodule
